sim_console_mon: RTL

Parametrised simulation console and run-control monitor for SoC benches. It collects byte streams from `CH_NUM` independent character sources (CSR printf ports, UART sniffers) into per-channel line buffers and emits completed lines through one arbitrated output port. It also counts simulation cycles and resolves end-of-run as either a software end request or a cycle timeout. It instantiates beside `sparrow_soc` in `tb_soc`, and its outputs drive display and `$stop` logic.

---
 rtl/sim_mon_pkg.sv | 27 ++
 rtl/sim_line_buf.sv | 93 +++++++++
 rtl/sim_console_mon.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sim_mon_pkg.sv
// Shared types and constants for the simulation console / run-control monitor.
package sim_mon_pkg;

    // Per-channel line buffer state: collecting characters, or holding a
    // completed line until the arbiter takes it.
    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } ch_state_e;

    // Global run-control state. DONE and TOUT are terminal until reset.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        TOUT  = 2'd3
    } run_state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // True for either line terminator; CR and LF are treated identically.
    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_LF) || (b == ASCII_CR);
    endfunction

endpackage

// File: rtl/sim_line_buf.sv
// One character channel: assembles bytes into a line, character 0 in the
// top byte, and holds the completed line in PEND until it is granted.
module sim_line_buf
    import sim_mon_pkg::*;
#(
    parameter int LINE_LEN = 64,
    parameter int LEN_W    = $clog2(LINE_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  accept_en,   // global state will be RUN next cycle
    input  logic                  force_flush, // push a partial line to PEND
    input  logic                  grant,       // output register takes this line
    output logic                  ready,
    output logic                  pend,
    output logic                  empty,
    output logic [LINE_LEN*8-1:0] data,
    output logic [LEN_W-1:0]      len
);

    ch_state_e             state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LINE_LEN*8-1:0] data_q, data_d;
    logic                  ready_q;
    logic                  xfer;

    assign xfer  = in_valid && ready_q;
    assign ready = ready_q;
    assign pend  = (state_q == PEND);
    assign empty = (state_q == FILL) && (len_q == '0);
    assign data  = data_q;
    assign len   = len_q;

    // Next-state decode for the buffer contents and FILL/PEND FSM.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        len_d   = len_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (xfer) begin
                    if (is_term(in_data)) begin
                        // Empty lines are dropped so CRLF yields a single line.
                        if (len_q != '0) begin
                            state_d = PEND;
                        end
                    end else begin
                        data_d[(LINE_LEN - 1 - int'(len_q)) * 8 +: 8] = in_data;
                        len_d = len_q + LEN_W'(1);
                        // A full buffer flushes; the next byte starts a new line.
                        if (len_d == LEN_W'(LINE_LEN)) begin
                            state_d = PEND;
                        end
                    end
                end else if (force_flush && (len_q != '0)) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (grant) begin
                    state_d = FILL;
                    len_d   = '0;
                    data_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Buffer registers plus the registered ch_ready decode of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the line storage is cleared on reset because unused bytes
            // must read as zero on the output; it cannot be left undefined.
            state_q <= FILL;
            len_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            len_q   <= len_d;
            data_q  <= data_d;
            ready_q <= (state_d == FILL) && accept_en;
        end
    end

endmodule

// File: rtl/sim_console_mon.sv
// Simulation console and run-control monitor: per-channel line buffers,
// round-robin line arbiter, output register, cycle counter and run FSM.
module sim_console_mon
    import sim_mon_pkg::*;
#(
    parameter  int CH_NUM      = 2,
    parameter  int LINE_LEN    = 64,
    parameter  int TIMEOUT_CYC = 60000,
    parameter  int CNT_W       = 64,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int LEN_W       = $clog2(LINE_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_NUM-1:0]     ch_valid,
    input  logic [CH_NUM*8-1:0]   ch_data,
    output logic [CH_NUM-1:0]     ch_ready,
    input  logic                  end_req,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [CH_W-1:0]       line_ch,
    output logic [LINE_LEN*8-1:0] line_data,
    output logic [LEN_W-1:0]      line_len,
    output logic [CNT_W-1:0]      sim_cycle,
    output logic                  done,
    output logic                  timeout
);

    run_state_e            run_q, run_d;
    logic [CNT_W-1:0]      cycle_q;

    logic [CH_NUM-1:0]     pend_v;
    logic [CH_NUM-1:0]     empty_v;
    logic [CH_NUM-1:0]     gnt_v;
    logic [LINE_LEN*8-1:0] buf_data [CH_NUM];
    logic [LEN_W-1:0]      buf_len  [CH_NUM];

    logic                  gnt_found;
    logic [CH_W-1:0]       gnt_idx;
    logic [CH_W-1:0]       ptr_q;
    logic                  load_en;

    logic                  out_valid_q;
    logic [CH_W-1:0]       out_ch_q;
    logic [LINE_LEN*8-1:0] out_data_q;
    logic [LEN_W-1:0]      out_len_q;

    logic                  accept_en;
    logic                  drain_flush;
    logic                  all_idle;
    logic                  done_cond;
    logic                  tout_hit;
    logic                  counting;

    assign accept_en   = (run_d == RUN);
    assign drain_flush = (run_q == DRAIN);

    genvar g;
    generate
        for (g = 0; g < CH_NUM; g++) begin : g_ch
            sim_line_buf #(
                .LINE_LEN (LINE_LEN),
                .LEN_W    (LEN_W)
            ) u_buf (
                .clk         (clk),
                .rst         (rst),
                .in_valid    (ch_valid[g]),
                .in_data     (ch_data[g*8 +: 8]),
                .accept_en   (accept_en),
                .force_flush (drain_flush),
                .grant       (gnt_v[g]),
                .ready       (ch_ready[g]),
                .pend        (pend_v[g]),
                .empty       (empty_v[g]),
                .data        (buf_data[g]),
                .len         (buf_len[g])
            );
        end
    endgenerate

    // Round-robin search for the first PEND channel at or after the pointer.
    always_comb begin
        int k;
        k         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            k = int'(ptr_q) + i;
            if (k >= CH_NUM) begin
                k = k - CH_NUM;
            end
            if (!gnt_found && pend_v[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(k);
            end
        end
    end

    // A line loads when the output register is empty or drains this cycle.
    assign load_en = gnt_found && (!out_valid_q || line_ready);
    assign gnt_v   = load_en ? (CH_NUM'(1) << gnt_idx) : '0;

    // Arbiter pointer moves to one past the channel just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load_en) begin
            ptr_q <= (int'(gnt_idx) == CH_NUM - 1) ? '0 : gnt_idx + CH_W'(1);
        end
    end

    // Output register: holds steady while stalled, reloads on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_len_q   <= '0;
        end else if (load_en) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= gnt_idx;
            out_data_q  <= buf_data[gnt_idx];
            out_len_q   <= buf_len[gnt_idx];
        end else if (line_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign line_valid = out_valid_q;
    assign line_ch    = out_ch_q;
    assign line_data  = out_data_q;
    assign line_len   = out_len_q;

    // End-of-run conditions, all from registered state.
    assign all_idle  = (&empty_v) && !out_valid_q;
    assign done_cond = (run_q == DRAIN) && all_idle;
    assign tout_hit  = ((run_q == RUN) || (run_q == DRAIN)) &&
                       (cycle_q == CNT_W'(TIMEOUT_CYC - 1));

    // Run FSM: a clean finish beats a timeout in the same cycle.
    always_comb begin
        run_d = run_q;
        case (run_q)
            RUN: begin
                if (tout_hit) begin
                    run_d = TOUT;
                end else if (end_req) begin
                    run_d = DRAIN;
                end
            end
            DRAIN: begin
                if (done_cond) begin
                    run_d = DONE;
                end else if (tout_hit) begin
                    run_d = TOUT;
                end
            end
            default: run_d = run_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= RUN;
        end else begin
            run_q <= run_d;
        end
    end

    // Cycle counter stops on the edge that enters a terminal state, so it
    // still shows the cycle in which the run ended.
    assign counting = ((run_q == RUN) || (run_q == DRAIN)) &&
                      ((run_d == RUN) || (run_d == DRAIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else if (counting) begin
            cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign sim_cycle = cycle_q;
    assign done      = (run_q == DONE);
    assign timeout   = (run_q == TOUT);

endmodule
